// File: rtl/sd_card_cmd_responder.sv
// sd_card_cmd_responder: card-side SD CMD line. Receives and checks 48-bit host
// commands, hands them to local card logic, and serialises the R1/R3/R6/R7
// (48-bit) or R2 (136-bit) response after the NCR turnaround.
// Ports: clock/reset (async, active-low); cmd_in/cmd_out/cmd_oe: CMD line;
//   cmd_valid/cmd_index/cmd_argument/crc_err/end_err: received command side;
//   resp_valid/resp_none/resp_long/resp_index/resp_data/resp_ack: response side;
//   busy: high whenever the responder is not idle.
// Macro SDCARD_CRC_CHECK_EN: when defined, the received CRC7 is verified;
//   otherwise the CRC field is ignored and crc_err is tied low.
module sd_card_cmd_responder #(
    parameter int NCR_CYCLES   = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_argument,
    output logic         crc_err,
    output logic         end_err,
    input  logic         resp_valid,
    input  logic         resp_none,
    input  logic         resp_long,
    input  logic [5:0]   resp_index,
    input  logic [127:0] resp_data,
    output logic         resp_ack,
    output logic         busy
);

    localparam int WAIT_W = $clog2(RESP_TIMEOUT + NCR_CYCLES + 2);
    localparam logic [WAIT_W-1:0] NCR_MIN = WAIT_W'(NCR_CYCLES - 1);
    localparam logic [WAIT_W-1:0] TMO_CNT = WAIT_W'(RESP_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        WAIT_RESP,
        SEND
    } state_t;

    state_t state, state_next;

    // Frame bits 46..0; the start bit is always 0 and not stored.
    logic [46:0]       rx_shift;
    logic [5:0]        bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [135:0]      tx_shift;
    logic [7:0]        tx_cnt;
    logic [39:0]       short_body;
    logic [135:0]      tx_frame;

    logic chk_ok;
    logic chk_end;
    logic none_ack;
    logic accept;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

`ifdef SDCARD_CRC_CHECK_EN
    logic [6:0] rx_crc;
    logic       crc_bad;
    logic       chk_crc;
    assign crc_bad = (rx_crc != rx_shift[7:1]);
`else
    logic unused_crc_field;
    assign unused_crc_field = ^rx_shift[7:1];
    assign crc_err = 1'b0;
`endif

    assign busy = (state != IDLE);

    // Response frame, left-aligned so the first bit to send is bit 135.
    always_comb begin
        short_body = {2'b00, resp_index, resp_data[31:0]};
        if (resp_long) begin
            tx_frame = {2'b00, 6'h3F, resp_data[127:1], 1'b1};
        end else begin
            tx_frame = {short_body, crc7_40(short_body), 1'b1, 88'd0};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        chk_ok     = 1'b0;
        chk_end    = 1'b0;
        none_ack   = 1'b0;
        accept     = 1'b0;
`ifdef SDCARD_CRC_CHECK_EN
        chk_crc    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!cmd_in) state_next = RECV;
            end
            RECV: begin
                if (bit_cnt == 6'd0) state_next = CHECK;
            end
            CHECK: begin
                state_next = IDLE;
                // Transmission bit 0 means another card's response: drop silently.
                if (rx_shift[46]) begin
                    if (!rx_shift[0]) begin
                        chk_end = 1'b1;
`ifdef SDCARD_CRC_CHECK_EN
                    end else if (crc_bad) begin
                        chk_crc = 1'b1;
`endif
                    end else begin
                        chk_ok     = 1'b1;
                        state_next = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (resp_valid && resp_none) begin
                    none_ack   = 1'b1;
                    state_next = IDLE;
                end else if (resp_valid && wait_cnt >= NCR_MIN) begin
                    accept     = 1'b1;
                    state_next = SEND;
                end else if (wait_cnt >= TMO_CNT) begin
                    state_next = IDLE;
                end
            end
            SEND: begin
                if (tx_cnt == 8'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_shift     <= '0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            cmd_out      <= 1'b1;
            cmd_oe       <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_index    <= '0;
            cmd_argument <= '0;
            end_err      <= 1'b0;
            resp_ack     <= 1'b0;
`ifdef SDCARD_CRC_CHECK_EN
            rx_crc       <= '0;
            crc_err      <= 1'b0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            end_err   <= chk_end;
            resp_ack  <= none_ack | accept;
`ifdef SDCARD_CRC_CHECK_EN
            crc_err   <= chk_crc;
            // The start bit is 0, so the CRC after it is still the zero init.
            if (state == IDLE) rx_crc <= '0;
            if (state == RECV && bit_cnt >= 6'd8) begin
                rx_crc <= crc7_step(rx_crc, cmd_in);
            end
`endif
            if (state == IDLE) begin
                bit_cnt <= 6'd46;
            end
            if (state == RECV) begin
                rx_shift <= {rx_shift[45:0], cmd_in};
                bit_cnt  <= bit_cnt - 6'd1;
            end
            if (chk_ok) begin
                cmd_valid    <= 1'b1;
                cmd_index    <= rx_shift[45:40];
                cmd_argument <= rx_shift[39:8];
                // The edge leaving CHECK is one clock after the end bit.
                wait_cnt     <= WAIT_W'(1);
            end
            if (state == WAIT_RESP) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (accept) begin
                cmd_oe   <= 1'b1;
                cmd_out  <= tx_frame[135];
                tx_shift <= {tx_frame[134:0], 1'b0};
                tx_cnt   <= resp_long ? 8'd135 : 8'd47;
            end
            if (state == SEND) begin
                if (tx_cnt == 8'd0) begin
                    cmd_oe  <= 1'b0;
                    cmd_out <= 1'b1;
                end else begin
                    cmd_out  <= tx_shift[135];
                    tx_shift <= {tx_shift[134:0], 1'b0};
                    tx_cnt   <= tx_cnt - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// tb_sd_card_cmd_responder: randomized and directed bench for the SD card
// CMD responder, compared against a frame-level reference model.
module tb_sd_card_cmd_responder;

    localparam int NCR = 2;
    localparam int TMO = 64;
`ifdef SDCARD_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    localparam int RK_NONE  = 0;
    localparam int RK_SHORT = 1;
    localparam int RK_LONG  = 2;
    localparam int RK_NEVER = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_in = 1'b1;
    logic         cmd_out;
    logic         cmd_oe;
    logic         cmd_valid;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_argument;
    logic         crc_err;
    logic         end_err;
    logic         resp_valid = 1'b0;
    logic         resp_none = 1'b0;
    logic         resp_long = 1'b0;
    logic [5:0]   resp_index = '0;
    logic [127:0] resp_data = '0;
    logic         resp_ack;
    logic         busy;

    int total = 0;
    int bad = 0;
    logic [135:0] last_bits;

    sd_card_cmd_responder #(
        .NCR_CYCLES   (NCR),
        .RESP_TIMEOUT (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_in       (cmd_in),
        .cmd_out      (cmd_out),
        .cmd_oe       (cmd_oe),
        .cmd_valid    (cmd_valid),
        .cmd_index    (cmd_index),
        .cmd_argument (cmd_argument),
        .crc_err      (crc_err),
        .end_err      (end_err),
        .resp_valid   (resp_valid),
        .resp_none    (resp_none),
        .resp_long    (resp_long),
        .resp_index   (resp_index),
        .resp_data    (resp_data),
        .resp_ack     (resp_ack),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [135:0] got,
                         input logic [135:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'd0};
        for (int b = 46; b >= 7; b--) begin
            if (v[b]) v = v ^ (47'h89 << (b - 7));
        end
        return v[6:0];
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx,
                                           input logic [31:0] arg);
        logic [39:0] body;
        body = {2'b01, idx, arg};
        return {body, ref_crc7(body), 1'b1};
    endfunction

    // 0 drop, 1 end error, 2 crc error, 3 accepted
    function automatic int classify(input logic [47:0] f);
        if (!f[46]) return 0;
        if (!f[0]) return 1;
        if (CRC_EN && ref_crc7(f[47:8]) != f[7:1]) return 2;
        return 3;
    endfunction

    function automatic logic [135:0] ref_resp(input bit lng, input logic [5:0] idx,
                                              input logic [127:0] d);
        logic [39:0] body;
        body = {2'b00, idx, d[31:0]};
        if (lng) return {2'b00, 6'h3F, d[127:1], 1'b1};
        return {88'd0, body, ref_crc7(body), 1'b1};
    endfunction

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            cmd_in = f[i];
            @(posedge clock);
            @(negedge clock);
        end
        cmd_in = 1'b1;
    endtask

    task automatic run_txn(input string tag, input logic [47:0] f, input int rk,
                           input int rv_edge, input logic [5:0] ridx,
                           input logic [127:0] rdata);
        int oc, e_aoff, e_roff, e_len, e_doff;
        bit acc, drive, acked;
        int vcnt, voff, ccnt, ecnt, acnt, aoff, roff, olen, doff, idle_bad;
        logic [5:0] vidx;
        logic [31:0] varg;
        logic [135:0] bits, e_bits;
        oc = classify(f);
        acc = (oc == 3);
        drive = acc && (rk != RK_NEVER);
        e_aoff = -1;
        e_roff = -1;
        e_len = 0;
        e_bits = '0;
        e_doff = 1;
        if (acc) begin
            if (rk == RK_NONE) begin
                e_aoff = (rv_edge > 2) ? rv_edge : 2;
                e_doff = e_aoff;
            end else if (rk == RK_NEVER) begin
                e_doff = TMO + 1;
            end else begin
                e_aoff = rv_edge;
                if (e_aoff < NCR) e_aoff = NCR;
                if (e_aoff < 2) e_aoff = 2;
                e_roff = e_aoff;
                e_len = (rk == RK_LONG) ? 136 : 48;
                e_bits = ref_resp(rk == RK_LONG, ridx, rdata);
                e_doff = e_aoff + e_len;
            end
        end
        resp_valid = 1'b0;
        resp_none = (rk == RK_NONE);
        resp_long = (rk == RK_LONG);
        resp_index = ridx;
        resp_data = rdata;
        send_frame(f);
        vcnt = 0; voff = -1; ccnt = 0; ecnt = 0; acnt = 0; aoff = -1;
        roff = -1; olen = 0; doff = -1; idle_bad = 0; acked = 1'b0;
        vidx = '0; varg = '0; bits = '0;
        resp_valid = drive && (rv_edge <= 1);
        for (int k = 1; k <= 400 && doff < 0; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (cmd_valid) begin
                vcnt++;
                voff = k;
                vidx = cmd_index;
                varg = cmd_argument;
            end
            if (crc_err) ccnt++;
            if (end_err) ecnt++;
            if (resp_ack) begin
                acnt++;
                aoff = k;
                acked = 1'b1;
            end
            if (cmd_oe) begin
                if (roff < 0) roff = k;
                olen++;
                bits = {bits[134:0], cmd_out};
            end else if (cmd_out !== 1'b1) begin
                idle_bad++;
            end
            if (!busy) doff = k;
            resp_valid = drive && !acked && (k + 1 >= rv_edge);
            if (acked) begin
                resp_data = {$urandom, $urandom, $urandom, $urandom};
                resp_index = 6'($urandom);
                resp_long = 1'($urandom);
                resp_none = 1'($urandom);
            end
        end
        resp_valid = 1'b0;
        last_bits = bits;
        check({tag, ":valid_cnt"}, 136'(vcnt), 136'(acc));
        check({tag, ":valid_off"}, 136'(voff), acc ? 136'(1) : 136'(-1));
        if (acc) begin
            check({tag, ":idx_arg"}, 136'({vidx, varg}), 136'(f[45:8]));
        end
        check({tag, ":crc_err"}, 136'(ccnt), 136'(oc == 2));
        check({tag, ":end_err"}, 136'(ecnt), 136'(oc == 1));
        check({tag, ":ack_cnt"}, 136'(acnt), 136'(e_aoff >= 0));
        check({tag, ":ack_off"}, 136'(aoff), 136'(e_aoff));
        check({tag, ":oe_rise"}, 136'(roff), 136'(e_roff));
        check({tag, ":oe_len"}, 136'(olen), 136'(e_len));
        check({tag, ":bits"}, bits, e_bits);
        check({tag, ":done_off"}, 136'(doff), 136'(e_doff));
        check({tag, ":idle_line"}, 136'(idle_bad), 136'(0));
    endtask

    initial begin
        logic [47:0] f;
        int sel, rk, k;
        logic [127:0] a5;
        a5 = {16{8'hA5}};
        repeat (3) @(negedge clock);
        check("rst_ctl", 136'({cmd_out, cmd_oe, cmd_valid, crc_err, end_err,
                               resp_ack, busy}), 136'(7'b1000000));
        check("rst_cmd", 136'({cmd_index, cmd_argument}), 136'(0));
        reset = 1'b1;
        @(negedge clock);

        run_txn("cmd0_none", 48'h400000000095, RK_NONE, 1, 6'd0, 128'd0);
        run_txn("cmd8", 48'h48000001AA87, RK_SHORT, 1, 6'd8, 128'h1AA);
        check("cmd8_frame", last_bits, 136'h08000001AA13);
        run_txn("cmd8_badcrc", 48'h48000001AA89, RK_SHORT, 1, 6'd8, 128'h1AA);
        run_txn("cmd8_end0", 48'h48000001AA86, RK_SHORT, 1, 6'd8, 128'h1AA);
        run_txn("tx0", 48'h08000001AA13, RK_SHORT, 1, 6'd8, 128'h1AA);
        run_txn("cmd2", mk_cmd(6'd2, 32'd0), RK_LONG, 1, 6'd2, a5);
        run_txn("cmd2_late", mk_cmd(6'd2, 32'd0), RK_LONG, 12, 6'd2, a5);
        run_txn("timeout", mk_cmd(6'd13, 32'h00010000), RK_NEVER, 1, 6'd0, 128'd0);

        for (int n = 0; n < 40; n++) begin
            f = mk_cmd(6'($urandom), $urandom);
            sel = $urandom_range(0, 9);
            if (sel == 6) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
            if (sel == 7) f[0] = 1'b0;
            if (sel == 8) f[46] = 1'b0;
            if (sel == 9) f[$urandom_range(0, 46)] ^= 1'b1;
            rk = ($urandom_range(0, 15) == 0) ? RK_NEVER : $urandom_range(0, 2);
            run_txn("rand", f, rk, $urandom_range(1, 20), 6'($urandom),
                    {$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        resp_none = 1'b0;
        resp_long = 1'b1;
        resp_data = {16{8'h5A}};
        resp_valid = 1'b1;
        send_frame(mk_cmd(6'd2, 32'd0));
        k = 0;
        while (!cmd_oe && k < 20) begin
            @(posedge clock);
            @(negedge clock);
            k++;
        end
        check("mid_oe_rise", 136'(cmd_oe), 136'(1));
        repeat (20) @(negedge clock);
        check("mid_oe_high", 136'(cmd_oe), 136'(1));
        #2 reset = 1'b0;
        #1;
        check("arst_line", 136'({cmd_oe, cmd_out, busy}), 136'(3'b010));
        resp_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_txn("post_rst_cmd0", 48'h400000000095, RK_NONE, 1, 6'd0, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
